serial_adder_n: RTL and testbench
=================================

Name: serial_adder_n

Overview:
Parametrised bit-serial adder. It is the sequential, N-bit successor to the team's combinational half/full adder cells, and it reuses a single full-adder slice over WIDTH cycles.
- Operands are accepted through a valid/ready handshake and added LSB first, one bit per clock.
- The carry is held in a flip-flop between bits.
- The result is presented through a second valid/ready handshake.
- Used where area matters more than throughput, e.g. accumulators in low-rate datapaths.

Parameters:
WIDTH, 8, operand and sum width in bits; legal range 2..64.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  operands a, b, cin are valid
in_ready  output  1  block can accept operands (high only in IDLE)
a  input  WIDTH  operand A, unsigned
b  input  WIDTH  operand B, unsigned
cin  input  1  carry in
out_valid  output  1  sum/cout hold a completed result
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result bits (a+b+cin) mod 2^WIDTH
cout  output  1  carry out of bit WIDTH-1
busy  output  1  high in ADD or DONE

Behaviour:
- Reset: clk and rst are the only clock and reset; rst is sampled on the rising edge of clk. When rst=1 at an edge:
  - state goes to IDLE;
  - in_ready=1, out_valid=0, busy=0;
  - sum=0, cout=0;
  - internal shift registers, carry flop and bit counter are cleared.
- FSM has three states: IDLE, ADD, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1:
    - capture a and b into shift registers;
    - carry flop <= cin;
    - sum register <= 0;
    - counter <= 0;
    - go to ADD.
  - With in_valid=0, stay in IDLE.
- ADD:
  - Each edge:
    - s = a_sr[0]^b_sr[0]^carry;
    - carry <= majority(a_sr[0], b_sr[0], carry);
    - a_sr, b_sr shift right by 1;
    - sum <= {s, sum[WIDTH-1:1]};
    - counter += 1.
  - After the edge that processes bit WIDTH-1 (counter == WIDTH-1), go to DONE.
  - Exactly WIDTH cycles are spent in ADD.
- DONE:
  - out_valid=1; sum holds the full result and cout = carry flop.
  - Both are held stable until an edge with out_ready=1, which moves the FSM to IDLE; out_valid=0 from the next cycle.
- Latency: accept edge at cycle k; out_valid is first high in the cycle after edge k+WIDTH.
- Throughput: one result per WIDTH+2 cycles minimum, with out_ready tied high.
- in_valid while not in IDLE is ignored; in_ready=0 in ADD and DONE.
  - The output handshake and a new input accept never occur on the same edge.
- sum and cout are only meaningful while out_valid=1.
  - During ADD, sum shows partial shift contents; checkers must not sample them then.
- Reset mid-operation (ADD or DONE) abandons the operation: IDLE with cleared outputs on the next cycle and no result emitted.
- Counter width is $clog2(WIDTH); there is no wrap beyond WIDTH-1.
- Widths: all arithmetic is unsigned modulo 2^WIDTH, with overflow reported only through cout.

Optional Feature:
Macro: SERIAL_ADDER_SUB_EN.
- When defined:
  - adds input port sub (1 bit), sampled with the operands on the accept edge;
  - sub=1 captures ~b into b_sr and loads the carry flop with 1 (cin ignored), giving sum = a-b mod 2^WIDTH;
  - cout=1 means no borrow (a>=b), cout=0 means borrow;
  - sub=0 behaves exactly as the base block.
- When undefined, there is no sub port and the block is add-only, with identical timing.

Test Plan:
1. Basic add, carry-out and latency (WIDTH=8, out_ready=1):
   - a=8'h0F, b=8'h01, cin=0 → sum=8'h10, cout=0; out_valid rises exactly 8 cycles after the accept edge, lasts 1 cycle, and in_ready returns high the cycle after.
   - a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1.
   - a=8'h00, b=8'h00, cin=1 → sum=8'h01, cout=0.
2. Backpressure: hold out_ready=0 for 5 cycles after out_valid rises, with in_valid=1 and new operands driven → sum/cout stable, in_ready=0, second operand not captured. The second operand is accepted only after the DONE→IDLE transition.
3. Reset mid-operation: assert rst for one edge on ADD cycle 3 of a=8'hAA, b=8'h55 → next cycle in_ready=1, out_valid=0, busy=0, sum=0, cout=0; no result appears later.
4. Exhaustive small width (WIDTH=2): all 32 (a,b,cin) combinations, compared against a+b+cin in a reference model → zero mismatches. The bit-0 slice matches the half/full adder truth table.
5. With SERIAL_ADDER_SUB_EN (WIDTH=8):
   - sub=1, a=8'h05, b=8'h07 → sum=8'hFE, cout=0.
   - sub=1, a=8'h07, b=8'h05 → sum=8'h02, cout=1.
   - sub=0 regression of scenario 1 passes unchanged.

Source files
------------

// File: rtl/serial_adder_n.sv
// serial_adder_n: parametrised bit-serial adder.
// One full-adder slice is reused over WIDTH clocks. Bits are processed LSB first.
// The carry is held in a flop between bits.
// Operands enter through a valid/ready handshake, and the result leaves through a second one.
// Optional feature macro: SERIAL_ADDER_SUB_EN adds a 'sub' input.
// With sub=1 the block loads ~b and a carry of 1, so it computes a-b.
module serial_adder_n #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [WIDTH-1:0] a_sr_r;
    logic [WIDTH-1:0] b_sr_r;
    logic [WIDTH-1:0] sum_r;
    logic             carry_r;
    logic [CNT_W-1:0] cnt_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             busy_r;
    logic [WIDTH-1:0] b_load_s;
    logic             carry_load_s;

    // Full-adder slice: sum bit
    function automatic logic fa_sum(input logic x, input logic y, input logic c);
        return x ^ y ^ c;
    endfunction

    // Full-adder slice: carry (majority of the three inputs)
    function automatic logic fa_carry(input logic x, input logic y, input logic c);
        return (x & y) | (x & c) | (y & c);
    endfunction

    // Next-state logic of the IDLE/ADD/DONE controller
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_next_s = ADD;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ADD: begin
                if (cnt_r == LAST_BIT) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = ADD;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Operand/carry values loaded on the accept edge (add, or subtract via ~b + 1)
    always_comb begin
        b_load_s     = b;
        carry_load_s = cin;
`ifdef SERIAL_ADDER_SUB_EN
        if (sub) begin
            b_load_s     = ~b;
            carry_load_s = 1'b1;
        end else begin
            b_load_s     = b;
            carry_load_s = cin;
        end
`endif
    end

    // State register and registered handshake/status flags decoded from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            in_ready_r  <= (state_next_s == IDLE);
            out_valid_r <= (state_next_s == DONE);
            busy_r      <= (state_next_s != IDLE);
        end
    end

    // Datapath: capture operands, then shift one bit per clock through the slice
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr_r  <= '0;
            b_sr_r  <= '0;
            sum_r   <= '0;
            carry_r <= 1'b0;
            cnt_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_sr_r  <= a;
                        b_sr_r  <= b_load_s;
                        carry_r <= carry_load_s;
                        sum_r   <= '0;
                        cnt_r   <= '0;
                    end else begin
                        cnt_r   <= cnt_r;
                    end
                end
                ADD: begin
                    sum_r   <= {fa_sum(a_sr_r[0], b_sr_r[0], carry_r), sum_r[WIDTH-1:1]};
                    carry_r <= fa_carry(a_sr_r[0], b_sr_r[0], carry_r);
                    a_sr_r  <= {1'b0, a_sr_r[WIDTH-1:1]};
                    b_sr_r  <= {1'b0, b_sr_r[WIDTH-1:1]};
                    // Counter stops at the last bit index instead of wrapping
                    if (cnt_r != LAST_BIT) begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                DONE: begin
                    sum_r   <= sum_r;
                    carry_r <= carry_r;
                end
                default: begin
                    sum_r   <= sum_r;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign sum       = sum_r;
    assign cout      = carry_r;

endmodule

// File: tb/tb_serial_adder_n.sv
// Self-checking bench for serial_adder_n.
// It drives a WIDTH=8 instance with directed and random operations, and
// a WIDTH=2 instance exhaustively. Results are compared against an arithmetic model.
// When SERIAL_ADDER_SUB_EN is defined, subtraction is exercised too.
module tb_serial_adder_n;

    logic       clk = 1'b0;
    logic       rst;
    // WIDTH=8 instance
    logic       in_valid8, in_ready8, cin8, out_valid8, out_ready8, cout8, busy8, sub8;
    logic [7:0] a8, b8, sum8;
    // WIDTH=2 instance
    logic       in_valid2, in_ready2, cin2, out_valid2, out_ready2, cout2, busy2, sub2;
    logic [1:0] a2, b2, sum2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_adder_n #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub8),
`endif
        .out_valid(out_valid8), .out_ready(out_ready8), .sum(sum8),
        .cout(cout8), .busy(busy8)
    );

    serial_adder_n #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .cin(cin2),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub2),
`endif
        .out_valid(out_valid2), .out_ready(out_ready2), .sum(sum2),
        .cout(cout2), .busy(busy2)
    );

    // Single comparison point: counts every check and reports mismatches
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: {cout,sum} of an 8-bit add or subtract
    function automatic logic [8:0] model8(input logic [7:0] x, input logic [7:0] y,
                                          input logic c, input logic s);
        int unsigned r;
        if (s) r = int'(x) + (255 - int'(y)) + 1;
        else   r = int'(x) + int'(y) + int'(c);
        return r[8:0];
    endfunction

    // One full operation on the 8-bit instance; 'hold' cycles of backpressure with junk input
    task automatic do_op8(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                          input logic ts, input int hold, input string tag);
        int cyc;
        logic [8:0] exp;
        exp = model8(ta, tb_v, tc, ts);
        a8 = ta; b8 = tb_v; cin8 = tc; sub8 = ts; in_valid8 = 1'b1; out_ready8 = (hold == 0);
        check_eq({tag, "/in_ready_pre"}, 64'(in_ready8), 64'd1);
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        cyc = 0;
        while (!out_valid8 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_eq({tag, "/latency"}, 64'(cyc), 64'd8);
        check_eq({tag, "/sum"}, 64'(sum8), 64'(exp[7:0]));
        check_eq({tag, "/cout"}, 64'(cout8), 64'(exp[8]));
        for (int i = 0; i < hold; i++) begin
            in_valid8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            @(posedge clk); #1;
            check_eq({tag, "/bp_valid"}, 64'(out_valid8), 64'd1);
            check_eq({tag, "/bp_in_ready"}, 64'(in_ready8), 64'd0);
            check_eq({tag, "/bp_sum"}, 64'({cout8, sum8}), 64'(exp));
        end
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        check_eq({tag, "/post_valid"}, 64'(out_valid8), 64'd0);
        check_eq({tag, "/post_in_ready"}, 64'(in_ready8), 64'd1);
        check_eq({tag, "/post_busy"}, 64'(busy8), 64'd0);
    endtask

    initial begin
        int cyc;
        int seen;
        logic [2:0] exp2;
        rst = 1'b1;
        in_valid8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0; sub8 = 1'b0; out_ready8 = 1'b1;
        in_valid2 = 1'b0; a2 = 2'b00; b2 = 2'b00; cin2 = 1'b0; sub2 = 1'b0; out_ready2 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("reset/in_ready", 64'(in_ready8), 64'd1);
        check_eq("reset/out_valid", 64'(out_valid8), 64'd0);
        check_eq("reset/busy", 64'(busy8), 64'd0);
        check_eq("reset/sum_cout", 64'({cout8, sum8}), 64'd0);

        // Basic adds
        do_op8(8'h0F, 8'h01, 1'b0, 1'b0, 0, "add_0f_01");
        do_op8(8'hFF, 8'h01, 1'b0, 1'b0, 0, "add_ff_01");
        do_op8(8'h00, 8'h00, 1'b1, 1'b0, 0, "add_cin");
        do_op8(8'hFF, 8'hFF, 1'b1, 1'b0, 0, "add_max");

        // Backpressure: 5 cycles with new operands offered, which must be ignored
        do_op8(8'h3C, 8'h5A, 1'b1, 1'b0, 5, "backpressure");
        do_op8(8'h81, 8'h7F, 1'b0, 1'b0, 0, "after_bp");

        // Reset on ADD cycle 3
        a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check_eq("midrst/busy_before", 64'(busy8), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("midrst/in_ready", 64'(in_ready8), 64'd1);
        check_eq("midrst/out_valid", 64'(out_valid8), 64'd0);
        check_eq("midrst/busy", 64'(busy8), 64'd0);
        check_eq("midrst/sum_cout", 64'({cout8, sum8}), 64'd0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid8) seen++;
        end
        check_eq("midrst/no_result", 64'(seen), 64'd0);

`ifdef SERIAL_ADDER_SUB_EN
        do_op8(8'h05, 8'h07, 1'b0, 1'b1, 0, "sub_5_7");
        do_op8(8'h07, 8'h05, 1'b1, 1'b1, 0, "sub_7_5");
        do_op8(8'h0F, 8'h01, 1'b0, 1'b0, 0, "sub0_regress");
`endif

        // Randomized operations with random backpressure
        for (int i = 0; i < 24; i++) begin
            logic rs;
            rs = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            rs = 1'($urandom);
`endif
            do_op8(8'($urandom), 8'($urandom), 1'($urandom), rs,
                   int'($urandom_range(0, 3)), "random");
        end

        // Exhaustive WIDTH=2 sweep
        for (int v = 0; v < 32; v++) begin
            logic [4:0] vv;
            vv = 5'(v);
            a2 = vv[1:0]; b2 = vv[3:2]; cin2 = vv[4];
            exp2 = 3'(int'(a2) + int'(b2) + int'(cin2));
            in_valid2 = 1'b1;
            @(posedge clk); #1;
            in_valid2 = 1'b0;
            cyc = 0;
            while (!out_valid2 && cyc < 20) begin
                @(posedge clk); #1;
                cyc++;
            end
            check_eq("w2/latency", 64'(cyc), 64'd2);
            check_eq("w2/result", 64'({cout2, sum2}), 64'(exp2));
            @(posedge clk); #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
